// File: rtl/hash_tagger.sv
// Three-stage tuple tagger: attaches an fmix32-style digest, an acceptance serial number
// and the was_joined flag, with valid/ready backpressure and a sticky drained-stream flag.
module hash_tagger #(
  parameter int          INPUT_SIZE  = 64,
  parameter logic [31:0] SEED        = 32'h0,
  parameter logic [63:0] SERIAL_BASE = 64'h0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [INPUT_SIZE-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_was_joined,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  ready_4_output,
  output logic [INPUT_SIZE-1:0] out_data,
  output logic [31:0]           out_tag,
  output logic                  out_valid,
  output logic [63:0]           out_serialnum,
  output logic                  out_last_processed,
  output logic                  out_was_joined
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both high;
  // valid and payload hold steady until that edge, and ready may depend on this cycle's state.

  logic                  v1, v2;
  logic [INPUT_SIZE-1:0] d1, d2;
  logic [31:0]           h1, h2;
  logic [63:0]           s1, s2;
  logic                  j1, j2;
  logic [63:0]           serial_cnt;
  logic                  last_seen;

  logic        adv_o, adv_2, adv_1, accept;
  logic [31:0] key_fold, h1_next, h2_next, tag_next;

  always_comb begin
    key_fold = in_data[31:0] ^ in_data[63:32] ^ SEED;
    h1_next  = (key_fold ^ (key_fold >> 16)) * 32'h85EBCA6B;
    h2_next  = (h1 ^ (h1 >> 13)) * 32'hC2B2AE35;
    tag_next = h2 ^ (h2 >> 16);
  end

  // Each stage may load whenever it is empty or its occupant moves on, so bubbles collapse.
  assign adv_o    = ready_4_output | ~out_valid;
  assign adv_2    = ~v2 | adv_o;
  assign adv_1    = ~v1 | adv_2;
  assign in_ready = resetn & adv_1 & ~last_seen;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1         <= 1'b0;
      d1         <= '0;
      h1         <= '0;
      s1         <= '0;
      j1         <= 1'b0;
      serial_cnt <= SERIAL_BASE;
    end else if (adv_1) begin
      v1 <= accept;
      if (accept) begin
        d1         <= in_data;
        h1         <= h1_next;
        s1         <= serial_cnt;
        j1         <= in_was_joined;
        serial_cnt <= serial_cnt + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v2 <= 1'b0;
      d2 <= '0;
      h2 <= '0;
      s2 <= '0;
      j2 <= 1'b0;
    end else if (adv_2) begin
      v2 <= v1;
      if (v1) begin
        d2 <= d1;
        h2 <= h2_next;
        s2 <= s1;
        j2 <= j1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_tag        <= '0;
      out_serialnum  <= '0;
      out_was_joined <= 1'b0;
    end else if (adv_o) begin
      out_valid <= v2;
      if (v2) begin
        out_data       <= d2;
        out_tag        <= tag_next;
        out_serialnum  <= s2;
        out_was_joined <= j2;
      end
    end
  end

  // Done only once the stream has ended and no stage still holds a tuple.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_seen          <= 1'b0;
      out_last_processed <= 1'b0;
    end else begin
      last_seen          <= last_seen | in_last;
      out_last_processed <= out_last_processed | (last_seen & ~v1 & ~v2 & ~out_valid);
    end
  end

endmodule
